// File: rtl/burst_mem_writer.sv
// Burst writer: fills a 2**ADDR_WIDTH-entry word buffer from a valid/ready stream,
// starting at a given address with wrap-around; buffer exposed through a registered read port.
module burst_mem_writer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      wr_count_q, wr_count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  wr_en_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Next-state logic; handshake outputs are computed for the state being entered
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wr_count_d = wr_count_q;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        wr_en_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = start_address;
                    cnt_d      = (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
                    wr_count_d = '0;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_WRITE;
                        busy_d     = 1'b1;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                busy_d     = 1'b1;
                in_ready_d = 1'b1;
                if (in_valid) begin
                    wr_en_c    = 1'b1;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    wr_count_d = wr_count_q + CNT_W'(1);
                    if (wr_count_q == cnt_q - CNT_W'(1)) begin
                        state_d    = S_DONE;
                        busy_d     = 1'b0;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_count_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Buffer contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[addr_q] <= in_data;
        end
    end

    // Read samples the pre-write contents, so a colliding write shows up a cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_burst_mem_writer.sv
// Randomized bench for burst_mem_writer: a buffer model predicts read data and done
// pulses; expectations are queued by the driver and popped by a separate monitor.
module tb_burst_mem_writer;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_address;
    logic [AW:0]   word_count;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;

    burst_mem_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_address(start_address),
        .word_count   (word_count),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            known;
        logic [DW-1:0] val;
    } rd_exp_t;

    typedef struct {
        int cyc;
        int cnt;
    } done_exp_t;

    logic [DW-1:0] mem_m   [DEPTH];
    bit            known_m [DEPTH];
    rd_exp_t       rd_q[$];
    done_exp_t     done_q[$];
    logic [DW-1:0] data_q[$];
    bit            vpat_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int wa     = 0;
    bit rd_go  = 1'b0;
    bit rd_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_go;
    end

    // Monitor: read data one cycle after each issued address, and every done pulse
    always @(negedge clk) begin : monitor
        rd_exp_t   e;
        done_exp_t d;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                if (e.known) chk("rd_data", 32'(rd_data), 32'(e.val));
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                d = done_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(d.cyc));
                chk("done_wr_count", 32'(wr_count), 32'(d.cnt));
                chk("done_busy", 32'(busy), 32'd0);
            end
        end
    end

    // One clock: issue a read, apply an accepted write to the model after the edge
    task automatic tick(input int ra, input bit wr);
        rd_exp_t e;
        rd_addr = (ra < 0) ? AW'($urandom_range(DEPTH - 1)) : AW'(ra);
        e.known = known_m[rd_addr];
        e.val   = mem_m[rd_addr];
        rd_q.push_back(e);
        rd_go = 1'b1;
        @(posedge clk);
        if (wr) begin
            mem_m[wa]   = in_data;
            known_m[wa] = 1'b1;
        end
        @(negedge clk);
        rd_go = 1'b0;
    endtask

    task automatic burst(input int sa, input int wc, input int vprob, input bit inject,
                         input int abort_after);
        int n;
        int exp_n;
        int guard;
        bit v;
        bit aborted;
        exp_n         = (wc > 16) ? 16 : wc;
        start         = 1'b1;
        start_address = AW'(sa);
        word_count    = (AW + 1)'(wc);
        in_valid      = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        if (exp_n == 0) done_q.push_back('{cyc + 1, 0});
        tick(-1, 1'b0);
        start   = 1'b0;
        wa      = sa;
        n       = 0;
        guard   = 0;
        aborted = 1'b0;
        while (n < exp_n && guard < 400 && !aborted) begin
            if (n == abort_after) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_wr_count", 32'(wr_count), 32'd0);
                chk("rst_rd_data", 32'(rd_data), 32'd0);
                @(posedge clk);
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                if (vpat_q.size() > 0) v = vpat_q.pop_front();
                else v = ($urandom_range(99) < 32'(vprob));
                in_valid = v;
                if (v && data_q.size() > 0) in_data = data_q.pop_front();
                else in_data = DW'($urandom);
                chk("wr_in_ready", 32'(in_ready), 32'd1);
                chk("wr_busy", 32'(busy), 32'd1);
                chk("wr_count_live", 32'(wr_count), 32'(n));
                if (inject && n == 1) begin
                    start         = 1'b1;
                    start_address = AW'(9);
                    word_count    = (AW + 1)'(7);
                end
                if (v && n == exp_n - 1) done_q.push_back('{cyc + 1, exp_n});
                tick((n % 2 == 1) ? wa : -1, v);
                start    = 1'b0;
                in_valid = 1'b0;
                if (v) begin
                    wa = (wa + 1) % 16;
                    n++;
                end
                guard++;
            end
        end
        if (guard >= 400) chk("burst_timeout", 32'd1, 32'd0);
        if (!aborted) begin
            chk("done_in_ready", 32'(in_ready), 32'd0);
            if (inject) begin
                start         = 1'b1;
                start_address = AW'(9);
                word_count    = (AW + 1)'(7);
            end
            tick(-1, 1'b0);
            start = 1'b0;
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_in_ready", 32'(in_ready), 32'd0);
            chk("post_wr_count", 32'(wr_count), 32'(exp_n));
            tick(-1, 1'b0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        start_address = '0;
        word_count    = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        rd_addr       = '0;
        for (int i = 0; i < int'(DEPTH); i++) known_m[i] = 1'b0;

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_wr_count", 32'(wr_count), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        #8 reset = 1'b0;

        // Basic three-word burst, then read it back
        data_q = '{16'h1111, 16'h2222, 16'h3333};
        burst(5, 3, 100, 1'b0, -1);
        tick(5, 1'b0);
        tick(6, 1'b0);
        tick(7, 1'b0);

        // Wrap past the top of the buffer
        data_q = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
        burst(14, 4, 100, 1'b0, -1);
        for (int a = 14; a < 18; a++) tick(a % 16, 1'b0);

        // Backpressure gaps
        vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1};
        burst(0, 2, 100, 1'b0, -1);
        tick(0, 1'b0);
        tick(1, 1'b0);

        // Full fill, then a start that must be ignored while busy and in DONE
        burst(0, 16, 70, 1'b0, -1);
        burst(2, 6, 100, 1'b1, -1);
        tick(9, 1'b0);
        tick(2, 1'b0);

        // Zero-length burst
        burst(11, 0, 100, 1'b0, -1);

        // Reset after two of five words, then a normal burst
        burst(3, 5, 100, 1'b0, 2);
        tick(3, 1'b0);
        tick(4, 1'b0);
        tick(5, 1'b0);
        burst(10, 3, 80, 1'b0, -1);

        // Oversized count clamps to a full buffer
        burst(7, 20, 100, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            burst(int'($urandom_range(15)), int'($urandom_range(20)),
                  int'($urandom_range(100, 40)), 1'b0, -1);
            tick(-1, 1'b0);
            tick(-1, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("pending_done", 32'(done_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
